// File: rtl/aes_block_display_pager.sv
// Assembles two 64-bit beats into a 128-bit block, double-buffers it and pages it over eight 7-seg digits.
// Optional hold input for freezing the page is compiled in with AES_DISP_HOLD_EN.
//
// state   | meaning
// WAIT_HI | ready for beat 0 (block[127:64])
// WAIT_LO | ready for beat 1 (block[63:0])
// COMMIT  | one cycle: shadow -> display, page/timer restart
module aes_block_display_pager #(
  parameter int TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
`ifdef AES_DISP_HOLD_EN
  input  logic        hold,
`endif
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [6:0]  hex6,
  output logic [6:0]  hex7,
  output logic [1:0]  page,
  output logic        blk_valid
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {WAIT_HI, WAIT_LO, COMMIT} state_t;

  state_t          state_q, state_d;
  logic [127:0]    shadow_q, shadow_d;
  logic [127:0]    disp_q, disp_d;
  logic [1:0]      page_q, page_d;
  logic            blk_valid_q, blk_valid_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            in_ready_q, in_ready_d;
  logic [6:0]      hex_q [8];
  logic [6:0]      hex_d [8];
  logic [31:0]     page_word;
  logic            tick;
  logic            hold_w;

`ifdef AES_DISP_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  function automatic logic [6:0] seg7(input logic [3:0] n);
    seg7 = 7'b1111111;
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      4'hF: seg7 = 7'b0001110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign tick = (timer_q == TMAX);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    disp_d      = disp_q;
    page_d      = page_q;
    blk_valid_d = blk_valid_q;
    timer_d     = tick ? '0 : timer_q + TW'(1);

    if (tick && blk_valid_q && !hold_w) page_d = page_q + 2'd1;

    case (state_q)
      WAIT_HI: if (in_valid && in_ready_q) begin
        shadow_d[127:64] = in_data;
        state_d          = WAIT_LO;
      end
      WAIT_LO: if (in_valid && in_ready_q) begin
        shadow_d[63:0] = in_data;
        state_d        = COMMIT;
      end
      COMMIT: begin
        // commit overrides any coincident tick
        disp_d      = shadow_q;
        page_d      = 2'd0;
        timer_d     = '0;
        blk_valid_d = 1'b1;
        state_d     = WAIT_HI;
      end
      default: state_d = WAIT_HI;
    endcase

    in_ready_d = (state_d != COMMIT);

    page_word = 32'h0;
    case (page_d)
      2'd0: page_word = disp_d[127:96];
      2'd1: page_word = disp_d[95:64];
      2'd2: page_word = disp_d[63:32];
      2'd3: page_word = disp_d[31:0];
      default: page_word = 32'h0;
    endcase

    // digits are registered from next-state so they move together with page/blk_valid
    for (int i = 0; i < 8; i++) begin
      hex_d[i] = blk_valid_d ? seg7(page_word[4*i +: 4]) : 7'b1111111;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_HI;
      shadow_q    <= '0;
      disp_q      <= '0;
      page_q      <= 2'd0;
      blk_valid_q <= 1'b0;
      timer_q     <= '0;
      in_ready_q  <= 1'b1;
      for (int i = 0; i < 8; i++) hex_q[i] <= 7'b1111111;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      disp_q      <= disp_d;
      page_q      <= page_d;
      blk_valid_q <= blk_valid_d;
      timer_q     <= timer_d;
      in_ready_q  <= in_ready_d;
      for (int i = 0; i < 8; i++) hex_q[i] <= hex_d[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign page      = page_q;
  assign blk_valid = blk_valid_q;
  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule

// File: tb/tb_aes_block_display_pager.sv
// Directed bench for aes_block_display_pager with TICK_DIV=4; hold checks compile in with AES_DISP_HOLD_EN.
module tb_aes_block_display_pager;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
`ifdef AES_DISP_HOLD_EN
  logic        hold;
`endif
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [1:0]  page;
  logic        blk_valid;
  logic [55:0] hexall;

  int n_checks = 0;
  int n_err    = 0;

  localparam logic [55:0] BLANK = {8{7'b1111111}};

  aes_block_display_pager #(.TICK_DIV(4)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
`ifdef AES_DISP_HOLD_EN
    .hold(hold),
`endif
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
    .page(page),
    .blk_valid(blk_valid)
  );

  assign hexall = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24; 4'h3: r = 7'h30;
      4'h4: r = 7'h19; 4'h5: r = 7'h12; 4'h6: r = 7'h02; 4'h7: r = 7'h78;
      4'h8: r = 7'h00; 4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
      4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06; default: r = 7'h0E;
    endcase
    return r;
  endfunction

  function automatic logic [55:0] exp_hex(input logic [31:0] w);
    logic [55:0] r;
    for (int i = 0; i < 8; i++) r[7*i +: 7] = seg_ref(w[4*i +: 4]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [127:0] blks [3];
  logic [63:0]  beats [6];
  int           idx;

  initial begin
    blks[0] = {64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
    blks[1] = {64'hDEAD_BEEF_CAFE_F00D, 64'h1357_9BDF_2468_ACE0};
    blks[2] = {64'hC001_D00D_FACE_B00C, 64'h7654_3210_0BAD_F00D};
    for (int b = 0; b < 3; b++) begin
      beats[2*b]   = blks[b][127:64];
      beats[2*b+1] = blks[b][63:0];
    end

    reset = 1'b1; in_valid = 1'b0; in_data = 64'h0;
`ifdef AES_DISP_HOLD_EN
    hold = 1'b0;
`endif
    cyc(2);
    reset = 1'b0;
    chk("rst_hex", 64'(hexall), 64'(BLANK));
    chk("rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("rst_page", 64'(page), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // block A
    in_valid = 1'b1; in_data = 64'h0011_2233_4455_6677; cyc(1);
    in_data = 64'h8899_AABB_CCDD_EEFF; cyc(1);
    in_valid = 1'b0;
    chk("commit_in_ready", 64'(in_ready), 64'd0);
    chk("commit_hex_blank", 64'(hexall), 64'(BLANK));
    cyc(1);
    chk("a_blk_valid", 64'(blk_valid), 64'd1);
    chk("a_page0", 64'(page), 64'd0);
    chk("a_hex0", 64'(hexall), 64'(exp_hex(32'h0011_2233)));
    cyc(3);
    chk("a_page0_before_tick", 64'(page), 64'd0);
    cyc(1);
    chk("a_page1", 64'(page), 64'd1);
    chk("a_hex1", 64'(hexall), 64'(exp_hex(32'h4455_6677)));
    cyc(4);
    chk("a_page2", 64'(page), 64'd2);
    chk("a_hex2", 64'(hexall), 64'(exp_hex(32'h8899_AABB)));
    cyc(4);
    chk("a_page3", 64'(page), 64'd3);
    chk("a_hex3", 64'(hexall), 64'(exp_hex(32'hCCDD_EEFF)));
    cyc(4);
    chk("a_wrap_page", 64'(page), 64'd0);
    chk("a_wrap_hex", 64'(hexall), 64'(exp_hex(32'h0011_2233)));

    // only the first beat of the next block arrives
    in_valid = 1'b1; in_data = 64'hFFFF_FFFF_FFFF_FFFF; cyc(1);
    in_valid = 1'b0;
    chk("half_hex0", 64'(hexall), 64'(exp_hex(32'h0011_2233)));
    cyc(3);
    chk("half_hex1", 64'(hexall), 64'(exp_hex(32'h4455_6677)));
    cyc(7);
    chk("half_page2", 64'(page), 64'd2);
    chk("half_hex2", 64'(hexall), 64'(exp_hex(32'h8899_AABB)));
    in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF; cyc(1);
    in_valid = 1'b0;
    chk("lo_accept_old_hex", 64'(hexall), 64'(exp_hex(32'hCCDD_EEFF)));
    cyc(1);
    chk("b_page0", 64'(page), 64'd0);
    chk("b_hex0", 64'(hexall), 64'(exp_hex(32'hFFFF_FFFF)));
    cyc(8);
    chk("b_page2", 64'(page), 64'd2);
    chk("b_hex2", 64'(hexall), 64'(exp_hex(32'h0123_4567)));

    // in_valid held high, three blocks back-to-back
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'b1; in_data = beats[idx];
      chk("stream_in_ready", 64'(in_ready), ((c % 3) != 2) ? 64'd1 : 64'd0);
      if (c == 3 || c == 6) chk("stream_blk_hex", 64'(hexall), 64'(exp_hex(blks[c/3-1][127:96])));
      if ((c % 3) != 2) idx++;
      cyc(1);
    end
    in_valid = 1'b0;
    chk("stream_end_ready", 64'(in_ready), 64'd1);
    chk("stream_e_hex0", 64'(hexall), 64'(exp_hex(32'hC001_D00D)));
    cyc(4);
    chk("stream_e_hex1", 64'(hexall), 64'(exp_hex(32'hFACE_B00C)));
    cyc(4);
    chk("stream_e_hex2", 64'(hexall), 64'(exp_hex(32'h7654_3210)));
    cyc(4);
    chk("stream_e_hex3", 64'(hexall), 64'(exp_hex(32'h0BAD_F00D)));

    // reset after a lone first beat
    in_valid = 1'b1; in_data = 64'hAAAA_AAAA_AAAA_AAAA; cyc(1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_rst_blk_valid", 64'(blk_valid), 64'd0);
    chk("async_rst_hex", 64'(hexall), 64'(BLANK));
    chk("async_rst_page", 64'(page), 64'd0);
    cyc(1);
    reset = 1'b0;
    in_valid = 1'b1; in_data = 64'h0102_0304_0506_0708; cyc(1);
    in_data = 64'h1112_1314_1516_1718; cyc(1);
    in_valid = 1'b0;
    cyc(1);
    chk("abort_blk_valid", 64'(blk_valid), 64'd1);
    chk("abort_hex0", 64'(hexall), 64'(exp_hex(32'h0102_0304)));
    cyc(4);
    chk("abort_hex1", 64'(hexall), 64'(exp_hex(32'h0506_0708)));

`ifdef AES_DISP_HOLD_EN
    hold = 1'b1;
    cyc(8);
    chk("hold_page", 64'(page), 64'd1);
    chk("hold_hex", 64'(hexall), 64'(exp_hex(32'h0506_0708)));
    hold = 1'b0;
    cyc(3);
    chk("release_pre_tick", 64'(page), 64'd1);
    cyc(1);
    chk("release_page", 64'(page), 64'd2);
    chk("release_hex", 64'(hexall), 64'(exp_hex(32'h1112_1314)));
`else
    cyc(4);
    chk("nohold_page2", 64'(page), 64'd2);
    chk("nohold_hex2", 64'(hexall), 64'(exp_hex(32'h1112_1314)));
    cyc(4);
    chk("nohold_page3", 64'(page), 64'd3);
    chk("nohold_hex3", 64'(hexall), 64'(exp_hex(32'h1516_1718)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
